// File: rtl/dac_ctrl_pkg.sv
// Shared types and helpers for the DAC setpoint controller.
// Holds the FSM encoding, direction type and saturating step function.
package dac_ctrl_pkg;

    localparam int          DW_DEF     = 8;
    localparam logic [7:0]  INIT_DEF   = 8'd128;
    localparam int          COARSE_DEF = 16;
    localparam int          SW         = 32;

    typedef enum logic [2:0] {
        IDLE,
        HOLD_UP,
        REP_UP,
        HOLD_DN,
        REP_DN
    } state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DN
    } dir_t;

    // One extra bit catches both overflow past maxv and borrow below zero.
    function automatic logic [SW-1:0] sat_step(
        input logic [SW-1:0] value,
        input logic [SW-1:0] step,
        input dir_t          dir,
        input logic [SW-1:0] maxv
    );
        logic [SW:0] r;
        if (dir == DIR_UP) begin
            r = {1'b0, value} + {1'b0, step};
            if (r > {1'b0, maxv}) r = {1'b0, maxv};
        end else begin
            r = {1'b0, value} - {1'b0, step};
            if (r[SW]) r = '0;
        end
        return r[SW-1:0];
    endfunction

endpackage

// File: rtl/dac_setpoint_ctrl_repeat_timer.sv
// Down-counter pacing the long-press auto-repeat.
// Loads on demand, counts down while enabled and stops at zero.
module repeat_timer
    import dac_ctrl_pkg::*;
#(
    parameter int CW = 25
) (
    input  logic          clk50m,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (en_i && (cnt_q != '0))
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dac_setpoint_ctrl.sv
// Button-driven DSM DAC setpoint register with fine/coarse stepping,
// long-press auto-repeat and saturation at both ends.
module dac_setpoint_ctrl
    import dac_ctrl_pkg::*;
#(
    parameter int             DW       = DW_DEF,
    parameter logic [DW-1:0]  INIT     = DW'(INIT_DEF),
    parameter int             COARSE   = COARSE_DEF,
    parameter int             HOLD_CYC = 25_000_000,
    parameter int             REP_CYC  = 5_000_000,
    parameter int             CW       = 25
) (
    input  logic          clk50m,
    input  logic          rst_n,
    input  logic          up_hi,
    input  logic          up_dbnc,
    input  logic          dn_hi,
    input  logic          dn_dbnc,
    input  logic          mode_hi,
    output logic [DW-1:0] setpoint,
    output logic          step_sel,
    output logic          chg
);

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] REP_LD  = CW'(REP_CYC - 1);
    localparam logic [SW-1:0] MAXV    = SW'({DW{1'b1}});
    localparam logic [SW-1:0] STEP_C  = SW'(COARSE);

    state_t        state_q, state_d;
    logic [DW-1:0] sp_q, sp_d;
    logic          sel_q, sel_d;
    logic          chg_q, chg_d;

    logic          do_step;
    dir_t          dir;
    logic          ld;
    logic [CW-1:0] ld_val;
    logic          tmr_zero;
    logic [SW-1:0] step;
    logic [DW-1:0] nxt;

    repeat_timer #(.CW(CW)) u_tmr (
        .clk50m     (clk50m),
        .rst_n      (rst_n),
        .en_i       (state_q != IDLE),
        .load_i     (ld),
        .load_val_i (ld_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        do_step = 1'b0;
        dir     = DIR_UP;
        ld      = 1'b0;
        ld_val  = HOLD_LD;
        unique case (state_q)
            IDLE: begin
                // Mode toggles first so a coincident press uses the new step.
                sel_d = sel_q ^ mode_hi;
                if (up_hi && !dn_hi) begin
                    do_step = 1'b1;
                    ld      = 1'b1;
                    state_d = HOLD_UP;
                end else if (dn_hi && !up_hi) begin
                    do_step = 1'b1;
                    dir     = DIR_DN;
                    ld      = 1'b1;
                    state_d = HOLD_DN;
                end
            end
            HOLD_UP, REP_UP: begin
                if (!up_dbnc) begin
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    do_step = 1'b1;
                    ld      = 1'b1;
                    ld_val  = REP_LD;
                    state_d = REP_UP;
                end
            end
            HOLD_DN, REP_DN: begin
                dir = DIR_DN;
                if (!dn_dbnc) begin
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    do_step = 1'b1;
                    ld      = 1'b1;
                    ld_val  = REP_LD;
                    state_d = REP_DN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        step  = sel_d ? STEP_C : SW'(1);
        nxt   = DW'(sat_step(SW'(sp_q), step, dir, MAXV));
        sp_d  = sp_q;
        chg_d = 1'b0;
        if (do_step) begin
            sp_d  = nxt;
            chg_d = (nxt != sp_q);
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sp_q    <= INIT;
            sel_q   <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            sel_q   <= sel_d;
            chg_q   <= chg_d;
        end
    end

    assign setpoint = sp_q;
    assign step_sel = sel_q;
    assign chg      = chg_q;

endmodule

// File: tb/tb_dac_setpoint_ctrl.sv
// Scoreboard bench for dac_setpoint_ctrl with shortened hold/repeat times.
// Stimulus pushes expected (cycle, value) pairs; a monitor checks every chg.
module tb_dac_setpoint_ctrl;

    localparam int HOLD = 10;
    localparam int REP  = 4;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    logic       clk50m = 1'b0;
    logic       rst_n  = 1'b0;
    logic       up_hi = 1'b0, up_dbnc = 1'b0;
    logic       dn_hi = 1'b0, dn_dbnc = 1'b0;
    logic       mode_hi = 1'b0;
    logic [7:0] setpoint;
    logic       step_sel;
    logic       chg;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q[$];

    int   m_val = 128;
    bit   m_sel = 1'b0;

    dac_setpoint_ctrl #(
        .DW       (8),
        .INIT     (8'd128),
        .COARSE   (16),
        .HOLD_CYC (HOLD),
        .REP_CYC  (REP),
        .CW       (25)
    ) dut (
        .clk50m   (clk50m),
        .rst_n    (rst_n),
        .up_hi    (up_hi),
        .up_dbnc  (up_dbnc),
        .dn_hi    (dn_hi),
        .dn_dbnc  (dn_dbnc),
        .mode_hi  (mode_hi),
        .setpoint (setpoint),
        .step_sel (step_sel),
        .chg      (chg)
    );

    always #10 clk50m = ~clk50m;

    always @(posedge clk50m) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                     name, got, exp, cyc);
        end
    endtask

    always @(negedge clk50m) begin
        exp_t e;
        if (chg) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexp_chg: got setpoint %0d expected no chg (cyc %0d)",
                         setpoint, cyc);
            end else begin
                e = q.pop_front();
                chk("chg_val", int'(setpoint), int'(e.val));
                chk("chg_cyc", cyc, e.cyc);
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_chg: got no chg expected %0d at cyc %0d (now %0d)",
                     e.val, e.cyc, cyc);
        end
    end

    task automatic tick();
        @(negedge clk50m);
    endtask

    task automatic model_step(input bit up, input int edge_cyc);
        int st;
        int nv;
        st = m_sel ? 16 : 1;
        if (up) nv = (m_val + st > 255) ? 255 : m_val + st;
        else    nv = (m_val - st < 0) ? 0 : m_val - st;
        if (nv != m_val) q.push_back('{edge_cyc, 8'(nv)});
        m_val = nv;
    endtask

    task automatic reset_dut();
        tick();
        rst_n = 1'b0;
        up_hi = 0; up_dbnc = 0; dn_hi = 0; dn_dbnc = 0; mode_hi = 0;
        m_val = 128;
        m_sel = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic mode_pulse();
        mode_hi = 1'b1;
        m_sel   = ~m_sel;
        tick();
        mode_hi = 1'b0;
        tick();
        chk("step_sel", int'(step_sel), int'(m_sel));
    endtask

    // Press and hold for h cycles; predicts press and auto-repeat steps.
    task automatic press(input bit up, input int h);
        int base;
        int e;
        base = cyc;
        if (up) begin up_hi = 1; up_dbnc = 1; end
        else    begin dn_hi = 1; dn_dbnc = 1; end
        model_step(up, base + 1);
        e = base + 1 + HOLD;
        while (e <= base + h) begin
            model_step(up, e);
            e += REP;
        end
        tick();
        up_hi = 0;
        dn_hi = 0;
        repeat (h - 1) tick();
        up_dbnc = 0;
        dn_dbnc = 0;
        repeat (2) tick();
    endtask

    initial begin
        int base;

        // reset state and idle stability
        repeat (3) tick();
        #1;
        chk("rst_setpoint", int'(setpoint), 128);
        chk("rst_step_sel", int'(step_sel), 0);
        chk("rst_chg", int'(chg), 0);
        rst_n = 1'b1;
        repeat (100) tick();
        chk("idle_setpoint", int'(setpoint), 128);
        chk("idle_step_sel", int'(step_sel), 0);

        // short up press
        press(1'b1, 3);
        repeat (20) tick();
        chk("short_up", int'(setpoint), 129);

        // long hold with auto-repeat
        reset_dut();
        press(1'b1, 30);
        repeat (5) tick();
        chk("hold_up", int'(setpoint), 134);

        // coarse down presses to zero, last one saturated
        reset_dut();
        mode_pulse();
        for (int i = 0; i < 9; i++) press(1'b0, 2);
        chk("dn_floor", int'(setpoint), 0);
        chk("dn_floor_m", int'(setpoint), m_val);

        // climb to 250, then saturate at the top
        reset_dut();
        mode_pulse();
        for (int i = 0; i < 7; i++) press(1'b1, 2);
        mode_pulse();
        for (int i = 0; i < 10; i++) press(1'b1, 2);
        chk("at_250", int'(setpoint), 250);
        mode_pulse();
        press(1'b1, 2);
        chk("sat_255", int'(setpoint), 255);
        press(1'b1, 2);
        chk("sat_255b", int'(setpoint), 255);

        // simultaneous up and down: no step, still IDLE
        up_hi = 1; dn_hi = 1; up_dbnc = 1; dn_dbnc = 1;
        tick();
        up_hi = 0; dn_hi = 0;
        repeat (HOLD + 5) tick();
        up_dbnc = 0; dn_dbnc = 0;
        repeat (2) tick();
        chk("conflict", int'(setpoint), 255);
        mode_pulse();
        press(1'b0, 2);
        chk("fine_dn", int'(setpoint), 254);

        // reset in the middle of a hold
        reset_dut();
        mode_pulse();
        base = cyc;
        up_hi = 1; up_dbnc = 1;
        model_step(1'b1, base + 1);
        model_step(1'b1, base + 1 + HOLD);
        tick();
        up_hi = 0;
        repeat (11) tick();
        chk("pre_rst", int'(setpoint), 160);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sp", int'(setpoint), 128);
        chk("mid_rst_sel", int'(step_sel), 0);
        m_val = 128;
        m_sel = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        chk("no_resume", int'(setpoint), 128);
        up_dbnc = 0;
        repeat (3) tick();

        chk("q_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
